multi_warp_tblock_manager: RTL and testbench

MULTI_WARP_TBLOCK_MANAGER -- requirements
Module: multi_warp_tblock_manager

---
 rtl/multi_warp_tblock_manager_pkg.sv | 48 ++++
 rtl/multi_warp_tblock_manager_tblock_group_slot.sv | 84 ++++++++
 rtl/multi_warp_tblock_manager.sv | 198 +++++++++++++++++++
 tb/tb_multi_warp_tblock_manager.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_warp_tblock_manager_pkg.sv
// -----------------------------------------------------------------------------
// multi_warp_tblock_manager_pkg
// Shared compute-unit definitions for the thread-block manager: the sizing
// constants, the per-block parameter record copied to every warp of a group,
// the per-group state record, and a helper for round-robin index wrap.
// -----------------------------------------------------------------------------
package multi_warp_tblock_manager_pkg;

    // Sizing. NumWarps must be a multiple of WarpsPerTblock, and
    // WarpsPerTblock must be a power of two (1 gives per-warp operation).
    localparam int NumWarps       = 32;
    localparam int WarpsPerTblock = 4;
    localparam int NumGroups      = NumWarps / WarpsPerTblock;

    localparam int AddressWidth   = 32;
    localparam int TblockIdxBits  = 4;
    localparam int TblockIdBits   = 4;

    localparam int WidWidth       = (NumWarps > 1)       ? $clog2(NumWarps)       : 1;
    localparam int SubIdxWidth    = (WarpsPerTblock > 1) ? $clog2(WarpsPerTblock) : 1;
    localparam int GroupIdxWidth  = (NumGroups > 1)      ? $clog2(NumGroups)      : 1;

    // Parameters of a running thread block, shared by all warps of its group.
    typedef struct packed {
        logic [AddressWidth-1:0]  dp_addr;
        logic [TblockIdxBits-1:0] tblock_idx;
        logic [TblockIdBits-1:0]  tblock_id;
    } warp_data_t;

    // Everything one warp group remembers between cycles.
    typedef struct packed {
        logic                      occupied;
        logic [WarpsPerTblock-1:0] finished;
        logic [WarpsPerTblock-1:0] waiting;
        warp_data_t                data;
    } group_state_t;

    // (base + offset) modulo NumGroups, for offsets below NumGroups.
    function automatic logic [GroupIdxWidth-1:0] wrap_group_idx(input int base, input int offset);
        int sum;
        sum = base + offset;
        if (sum >= NumGroups) begin
            sum = sum - NumGroups;
        end
        return GroupIdxWidth'(sum);
    endfunction

endpackage

// File: rtl/multi_warp_tblock_manager_tblock_group_slot.sv
// -----------------------------------------------------------------------------
// tblock_group_slot
// State of one warp group: occupancy, per-warp finished / barrier-waiting bits,
// barrier release and the parameters of the block running in it.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   alloc_i             this group receives a new thread block this cycle
//   alloc_data_i        parameters of that block
//   free_i              completion handshake for this group, free it
//   stop_i              per-warp decode stop events (local warp order)
//   barrier_i           per-warp decode barrier events (local warp order)
//   ib_finished_i       per-warp "no instructions in flight"
//   occupied_o          group holds a thread block
//   complete_o          every warp finished and drained
//   warp_active_o       per-warp occupied, not finished, not waiting
//   data_o              parameters of the block held by this group
// -----------------------------------------------------------------------------
module tblock_group_slot
    import multi_warp_tblock_manager_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      alloc_i,
    input  warp_data_t                alloc_data_i,
    input  logic                      free_i,
    input  logic [WarpsPerTblock-1:0] stop_i,
    input  logic [WarpsPerTblock-1:0] barrier_i,
    input  logic [WarpsPerTblock-1:0] ib_finished_i,
    output logic                      occupied_o,
    output logic                      complete_o,
    output logic [WarpsPerTblock-1:0] warp_active_o,
    output warp_data_t                data_o
);

    group_state_t              state_q, state_d;
    logic [WarpsPerTblock-1:0] live_stop;
    logic [WarpsPerTblock-1:0] live_barrier;
    logic [WarpsPerTblock-1:0] arrived;
    logic                      release_barrier;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        live_stop    = stop_i    & {WarpsPerTblock{state_q.occupied}};
        live_barrier = barrier_i & {WarpsPerTblock{state_q.occupied}};

        // A warp has reached the barrier if it already waits, arrives now,
        // or has finished (including stopping this very cycle).
        arrived         = state_q.waiting | live_barrier | state_q.finished | live_stop;
        release_barrier = state_q.occupied & (&arrived) & (|(state_q.waiting | live_barrier));

        state_d.finished = state_q.finished | live_stop;
        state_d.waiting  = release_barrier ? '0 : (state_q.waiting | live_barrier);

        if (free_i) begin
            state_d = '0;
        end
        // The manager never allocates a group that is occupied, so alloc_i
        // and free_i cannot both be set for the same group.
        if (alloc_i) begin
            state_d          = '0;
            state_d.occupied = 1'b1;
            state_d.data     = alloc_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state updates use non-blocking assignments so every flop
        // samples values from before the edge, independent of block order.
        if (rst_i) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign occupied_o    = state_q.occupied;
    assign complete_o    = state_q.occupied & (&state_q.finished) & (&ib_finished_i);
    assign warp_active_o = {WarpsPerTblock{state_q.occupied}} & ~state_q.finished & ~state_q.waiting;
    assign data_o        = state_q.data;

endmodule

// File: rtl/multi_warp_tblock_manager.sv
// -----------------------------------------------------------------------------
// multi_warp_tblock_manager
// Assigns thread blocks to fixed warp groups of a compute unit, tracks warp
// stop / barrier state through one tblock_group_slot per group and reports
// finished blocks through a registered valid/ready completion channel that
// serves completed groups round-robin.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   group_free_o                  at least one group unoccupied
//   allocate_i                    start a block (accepted iff group_free_o)
//   allocate_dp_addr_i / _tblock_idx_i / _tblock_id_i   block parameters
//   warp_init_o                   init pulse for the warps of the new group
//   instruction_decoded_i         decode event valid
//   decode_stop_warp_i            event is a warp stop
//   decode_barrier_i              event is a barrier
//   decode_wid_i                  warp of the event
//   ib_all_instr_finished_i       per-warp pipeline drained
//   warp_active_o                 per-warp runnable
//   warp_dp_addr_o / warp_tblock_idx_o / warp_sub_idx_o  per-warp block info
//   tblock_done_o / tblock_done_ready_i / tblock_done_id_o completion channel
// -----------------------------------------------------------------------------
module multi_warp_tblock_manager
    import multi_warp_tblock_manager_pkg::*;
(
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    output logic                                      group_free_o,
    input  logic                                      allocate_i,
    input  logic [AddressWidth-1:0]                   allocate_dp_addr_i,
    input  logic [TblockIdxBits-1:0]                  allocate_tblock_idx_i,
    input  logic [TblockIdBits-1:0]                   allocate_tblock_id_i,
    output logic [NumWarps-1:0]                       warp_init_o,
    input  logic                                      instruction_decoded_i,
    input  logic                                      decode_stop_warp_i,
    input  logic                                      decode_barrier_i,
    input  logic [WidWidth-1:0]                       decode_wid_i,
    input  logic [NumWarps-1:0]                       ib_all_instr_finished_i,
    output logic [NumWarps-1:0]                       warp_active_o,
    output logic [NumWarps-1:0][AddressWidth-1:0]     warp_dp_addr_o,
    output logic [NumWarps-1:0][TblockIdxBits-1:0]    warp_tblock_idx_o,
    output logic [NumWarps-1:0][SubIdxWidth-1:0]      warp_sub_idx_o,
    output logic                                      tblock_done_o,
    input  logic                                      tblock_done_ready_i,
    output logic [TblockIdBits-1:0]                   tblock_done_id_o
);

    // Group status and per-group control.
    logic [NumGroups-1:0]     occupied_vec;
    logic [NumGroups-1:0]     complete_vec;
    logic [NumGroups-1:0]     alloc_vec;
    logic [NumGroups-1:0]     free_vec;
    warp_data_t               group_data [NumGroups];
    warp_data_t               alloc_data;

    // Per-warp decode events and occupancy.
    logic [NumWarps-1:0]      stop_vec;
    logic [NumWarps-1:0]      barrier_vec;
    logic [NumWarps-1:0]      warp_occ;

    logic [GroupIdxWidth-1:0] alloc_grp;
    logic                     accept;

    // Completion channel and round-robin pointer.
    logic                     done_q, done_d;
    logic [GroupIdxWidth-1:0] done_grp_q, done_grp_d;
    logic [TblockIdBits-1:0]  done_id_q, done_id_d;
    logic [GroupIdxWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic                     handshake;
    logic [NumGroups-1:0]     done_cand;
    logic                     sel_found;
    logic [GroupIdxWidth-1:0] sel_grp;

    assign alloc_data.dp_addr    = allocate_dp_addr_i;
    assign alloc_data.tblock_idx = allocate_tblock_idx_i;
    assign alloc_data.tblock_id  = allocate_tblock_id_i;

    // -------------------------------------------------------------------------
    // Allocation: lowest-index free group. group_free_o looks only at the
    // registered occupancy, so a group released by this cycle's handshake is
    // not visible as free until the next cycle.
    // -------------------------------------------------------------------------
    assign group_free_o = ~(&occupied_vec);
    assign accept       = allocate_i & group_free_o;

    always_comb begin
        alloc_grp = '0;
        // Descending scan: the last hit, i.e. the lowest free index, wins.
        for (int g = NumGroups - 1; g >= 0; g--) begin
            if (!occupied_vec[g]) begin
                alloc_grp = GroupIdxWidth'(g);
            end
        end
        for (int g = 0; g < NumGroups; g++) begin
            alloc_vec[g] = accept && (alloc_grp == GroupIdxWidth'(g));
            free_vec[g]  = handshake && (done_grp_q == GroupIdxWidth'(g));
        end
    end

    // -------------------------------------------------------------------------
    // Per-warp fan-out of group information and decode-event steering.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int w = 0; w < NumWarps; w++) begin
            warp_dp_addr_o[w]    = group_data[w / WarpsPerTblock].dp_addr;
            warp_tblock_idx_o[w] = group_data[w / WarpsPerTblock].tblock_idx;
            warp_sub_idx_o[w]    = SubIdxWidth'(w % WarpsPerTblock);
            warp_init_o[w]       = alloc_vec[w / WarpsPerTblock];
            warp_occ[w]          = occupied_vec[w / WarpsPerTblock];
            stop_vec[w]          = instruction_decoded_i && decode_stop_warp_i
                                   && (decode_wid_i == WidWidth'(w));
            barrier_vec[w]       = instruction_decoded_i && decode_barrier_i
                                   && (decode_wid_i == WidWidth'(w));
        end
    end

    for (genvar g = 0; g < NumGroups; g++) begin : g_slot
        tblock_group_slot u_slot (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .alloc_i       (alloc_vec[g]),
            .alloc_data_i  (alloc_data),
            .free_i        (free_vec[g]),
            .stop_i        (stop_vec[g*WarpsPerTblock +: WarpsPerTblock]),
            .barrier_i     (barrier_vec[g*WarpsPerTblock +: WarpsPerTblock]),
            .ib_finished_i (ib_all_instr_finished_i[g*WarpsPerTblock +: WarpsPerTblock]),
            .occupied_o    (occupied_vec[g]),
            .complete_o    (complete_vec[g]),
            .warp_active_o (warp_active_o[g*WarpsPerTblock +: WarpsPerTblock]),
            .data_o        (group_data[g])
        );
    end

    // -------------------------------------------------------------------------
    // Completion channel. A new group is picked whenever the channel is idle
    // or being emptied this cycle; the group being handed off is still
    // complete until its slot clears, so it is masked out of the search.
    // Search starts at rr_ptr_q, which points just past the last group served.
    // -------------------------------------------------------------------------
    assign handshake = done_q & tblock_done_ready_i;

    always_comb begin
        done_d     = done_q;
        done_grp_d = done_grp_q;
        done_id_d  = done_id_q;
        rr_ptr_d   = rr_ptr_q;
        done_cand  = complete_vec;
        sel_found  = 1'b0;
        sel_grp    = '0;

        if (handshake) begin
            done_cand[done_grp_q] = 1'b0;
        end

        // Descending offset scan: the nearest candidate after the pointer wins.
        for (int i = NumGroups - 1; i >= 0; i--) begin
            if (done_cand[wrap_group_idx(int'(rr_ptr_q), i)]) begin
                sel_found = 1'b1;
                sel_grp   = wrap_group_idx(int'(rr_ptr_q), i);
            end
        end

        if (!done_q || handshake) begin
            done_d = sel_found;
            if (sel_found) begin
                done_grp_d = sel_grp;
                done_id_d  = group_data[sel_grp].tblock_id;
                rr_ptr_d   = wrap_group_idx(int'(sel_grp), 1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q     <= 1'b0;
            done_grp_q <= '0;
            done_id_q  <= '0;
            rr_ptr_q   <= '0;
        end else begin
            done_q     <= done_d;
            done_grp_q <= done_grp_d;
            done_id_q  <= done_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign tblock_done_o    = done_q;
    assign tblock_done_id_o = done_id_q;

`ifndef SYNTHESIS
    // Decode events are dropped for unoccupied warps; flag them in simulation.
    a_decode_to_occupied_warp : assert property (
        @(posedge clk_i) disable iff (rst_i)
        instruction_decoded_i |-> warp_occ[decode_wid_i]
    );
`endif

endmodule

// File: tb/tb_multi_warp_tblock_manager.sv
// -----------------------------------------------------------------------------
// tb_multi_warp_tblock_manager
// Directed bench for multi_warp_tblock_manager: allocation, barrier release,
// completion ordering with a held-off consumer, full occupancy and reset
// during a pending completion. Completion ids are predicted into a queue when
// a block is made to finish and compared when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_multi_warp_tblock_manager;
    import multi_warp_tblock_manager_pkg::*;

    logic                                   clk;
    logic                                   rst;
    logic                                   group_free;
    logic                                   allocate;
    logic [AddressWidth-1:0]                allocate_dp_addr;
    logic [TblockIdxBits-1:0]               allocate_tblock_idx;
    logic [TblockIdBits-1:0]                allocate_tblock_id;
    logic [NumWarps-1:0]                    warp_init;
    logic                                   instruction_decoded;
    logic                                   decode_stop_warp;
    logic                                   decode_barrier;
    logic [WidWidth-1:0]                    decode_wid;
    logic [NumWarps-1:0]                    ib_all_instr_finished;
    logic [NumWarps-1:0]                    warp_active;
    logic [NumWarps-1:0][AddressWidth-1:0]  warp_dp_addr;
    logic [NumWarps-1:0][TblockIdxBits-1:0] warp_tblock_idx;
    logic [NumWarps-1:0][SubIdxWidth-1:0]   warp_sub_idx;
    logic                                   tblock_done;
    logic                                   tblock_done_ready;
    logic [TblockIdBits-1:0]                tblock_done_id;

    int n_checks = 0;
    int n_fail   = 0;

    logic [TblockIdBits-1:0] exp_q [$];

    multi_warp_tblock_manager dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .group_free_o            (group_free),
        .allocate_i              (allocate),
        .allocate_dp_addr_i      (allocate_dp_addr),
        .allocate_tblock_idx_i   (allocate_tblock_idx),
        .allocate_tblock_id_i    (allocate_tblock_id),
        .warp_init_o             (warp_init),
        .instruction_decoded_i   (instruction_decoded),
        .decode_stop_warp_i      (decode_stop_warp),
        .decode_barrier_i        (decode_barrier),
        .decode_wid_i            (decode_wid),
        .ib_all_instr_finished_i (ib_all_instr_finished),
        .warp_active_o           (warp_active),
        .warp_dp_addr_o          (warp_dp_addr),
        .warp_tblock_idx_o       (warp_tblock_idx),
        .warp_sub_idx_o          (warp_sub_idx),
        .tblock_done_o           (tblock_done),
        .tblock_done_ready_i     (tblock_done_ready),
        .tblock_done_id_o        (tblock_done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_blk(input logic [TblockIdBits-1:0] id, input logic [TblockIdxBits-1:0] idx,
                             input logic [AddressWidth-1:0] addr, input logic [NumWarps-1:0] exp_init);
        allocate            = 1'b1;
        allocate_tblock_id  = id;
        allocate_tblock_idx = idx;
        allocate_dp_addr    = addr;
        #1;
        check("warp_init_pulse", 64'(warp_init), 64'(exp_init));
        step();
        allocate = 1'b0;
        #1;
        check("warp_init_clear", 64'(warp_init), 64'h0);
    endtask

    task automatic decode(input int wid, input logic stop, input logic bar);
        instruction_decoded = 1'b1;
        decode_wid          = WidWidth'(wid);
        decode_stop_warp    = stop;
        decode_barrier      = bar;
        step();
        instruction_decoded = 1'b0;
        decode_stop_warp    = 1'b0;
        decode_barrier      = 1'b0;
    endtask

    // Complete one handshake against the oldest predicted id.
    task automatic serve();
        logic [TblockIdBits-1:0] exp_id;
        exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("done_pending", 64'(tblock_done), 64'h1);
        check("done_id", 64'(tblock_done_id), 64'(exp_id));
        tblock_done_ready = 1'b1;
        step();
        tblock_done_ready = 1'b0;
    endtask

    initial begin
        logic [NumWarps-1:0] exp_init;

        rst                   = 1'b1;
        allocate              = 1'b0;
        allocate_dp_addr      = '0;
        allocate_tblock_idx   = '0;
        allocate_tblock_id    = '0;
        instruction_decoded   = 1'b0;
        decode_stop_warp      = 1'b0;
        decode_barrier        = 1'b0;
        decode_wid            = '0;
        ib_all_instr_finished = '1;
        tblock_done_ready     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_group_free", 64'(group_free), 64'h1);
        check("rst_done", 64'(tblock_done), 64'h0);
        check("rst_done_id", 64'(tblock_done_id), 64'h0);
        check("rst_active", 64'(warp_active), 64'h0);
        check("rst_init", 64'(warp_init), 64'h0);
        rst = 1'b0;
        step();

        // Block id 3 lands in group 0, block id 5 in group 1.
        alloc_blk(4'd3, 4'd1, 32'h0000_1000, 32'h0000_000F);
        check("active_after_alloc", 64'(warp_active), 64'h0000_000F);
        for (int w = 0; w < 4; w++) begin
            check("sub_idx", 64'(warp_sub_idx[w]), 64'(w));
        end
        check("dp_addr_w2", 64'(warp_dp_addr[2]), 64'h1000);
        check("tblock_idx_w3", 64'(warp_tblock_idx[3]), 64'h1);
        alloc_blk(4'd5, 4'd2, 32'h0000_2000, 32'h0000_00F0);
        check("active_two_groups", 64'(warp_active), 64'h0000_00FF);
        check("dp_addr_w5", 64'(warp_dp_addr[5]), 64'h2000);

        // Warps 0..2 wait at a barrier, warp 3 stops and releases them.
        decode(0, 1'b0, 1'b1);
        check("bar_w0", 64'(warp_active), 64'h0000_00FE);
        decode(1, 1'b0, 1'b1);
        check("bar_w1", 64'(warp_active), 64'h0000_00FC);
        decode(2, 1'b0, 1'b1);
        check("bar_w2", 64'(warp_active), 64'h0000_00F8);
        decode(3, 1'b1, 1'b0);
        check("bar_release_on_stop", 64'(warp_active), 64'h0000_00F7);

        // Finish both groups while their pipelines are still busy.
        ib_all_instr_finished = '0;
        foreach (exp_init[i]) exp_init[i] = 1'b0;
        decode(0, 1'b1, 1'b0);
        decode(1, 1'b1, 1'b0);
        decode(2, 1'b1, 1'b0);
        for (int w = 4; w < 8; w++) begin
            decode(w, 1'b1, 1'b0);
        end
        check("all_stopped_inactive", 64'(warp_active), 64'h0);
        step();
        check("done_waits_for_ib", 64'(tblock_done), 64'h0);

        // Both complete in the same cycle; group 0 goes first, then group 1.
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd5);
        ib_all_instr_finished = '1;
        step();
        for (int i = 0; i < 5; i++) begin
            check("done_held", 64'(tblock_done), 64'h1);
            check("done_id_held", 64'(tblock_done_id), 64'h3);
            step();
        end
        serve();
        serve();
        check("done_drained", 64'(tblock_done), 64'h0);

        // Fill all eight groups in index order.
        for (int g = 0; g < NumGroups; g++) begin
            exp_init = NumWarps'(32'hF) << (4 * g);
            alloc_blk(TblockIdBits'(g + 8), TblockIdxBits'(g), AddressWidth'(32'h100 * g), exp_init);
        end
        check("full_group_free", 64'(group_free), 64'h0);
        check("full_active", 64'(warp_active), 64'hFFFF_FFFF);

        // Allocation while full is dropped.
        allocate = 1'b1;
        #1;
        check("full_alloc_no_init", 64'(warp_init), 64'h0);
        step();
        allocate = 1'b0;
        check("full_active_kept", 64'(warp_active), 64'hFFFF_FFFF);

        // Group 2 (id 10) completes.
        exp_q.push_back(4'd10);
        for (int w = 8; w < 12; w++) begin
            decode(w, 1'b1, 1'b0);
        end
        step();
        check("g2_done", 64'(tblock_done), 64'h1);
        check("g2_not_free_yet", 64'(group_free), 64'h0);

        // The group freed by this handshake is not allocatable in this cycle.
        allocate           = 1'b1;
        allocate_tblock_id = 4'd12;
        #1;
        check("free_same_cycle_no_init", 64'(warp_init), 64'h0);
        serve();
        allocate = 1'b0;
        check("free_next_cycle", 64'(group_free), 64'h1);
        check("done_idle_after_g2", 64'(tblock_done), 64'h0);
        check("g2_warps_idle", 64'(warp_active), 64'hFFFF_F0FF);
        alloc_blk(4'd13, 4'd0, 32'h0000_3000, 32'h0000_0F00);
        check("refull_group_free", 64'(group_free), 64'h0);

        // Reset while a completion is pending.
        for (int w = 8; w < 12; w++) begin
            decode(w, 1'b1, 1'b0);
        end
        step();
        check("pending_before_rst", 64'(tblock_done), 64'h1);
        check("pending_id_before_rst", 64'(tblock_done_id), 64'hD);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_done", 64'(tblock_done), 64'h0);
        check("midrst_done_id", 64'(tblock_done_id), 64'h0);
        check("midrst_active", 64'(warp_active), 64'h0);
        check("midrst_group_free", 64'(group_free), 64'h1);
        step();
        rst = 1'b0;
        step();
        check("postrst_active", 64'(warp_active), 64'h0);
        check("postrst_done", 64'(tblock_done), 64'h0);
        alloc_blk(4'd1, 4'd1, 32'h0000_4000, 32'h0000_000F);
        check("postrst_only_g0", 64'(warp_active), 64'h0000_000F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
